// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues word fetches to the instruction SRAM,
// tracks up to MAX_OUT outstanding requests in an in-flight FIFO, and buffers
// returned instructions in an IQ_DEPTH-entry queue that feeds the decode stage.
// Redirects (exception, ertn, branch) flush the queue and flip a 1-bit epoch so
// responses to requests issued before the redirect are dropped on return.
// A misaligned fetch address produces a single ADEF entry and halts fetching
// until the next redirect.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          MAX_OUT  = 2,
  parameter int          IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction SRAM request channel
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  // redirect sources and branch stall
  input  logic        ex_valid,
  input  logic [31:0] ex_entry,
  input  logic        ertn_valid,
  input  logic [31:0] era_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  // decode-side queue head
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adef
);

  // Pointer widths stay at least 1 bit so a depth of 1 still elaborates.
  localparam int OP_W  = (MAX_OUT  > 1) ? $clog2(MAX_OUT)  : 1;
  localparam int IP_W  = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  // Counter width must hold out_cnt + iq_cnt (each <= IQ_DEPTH) without wrap.
  localparam int CNT_W = $clog2(IQ_DEPTH + 1) + 1;

  localparam logic [CNT_W-1:0] MAX_OUT_C  = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] IQ_DEPTH_C = CNT_W'(IQ_DEPTH);
  localparam logic [OP_W-1:0]  OP_LAST    = OP_W'(MAX_OUT - 1);
  localparam logic [IP_W-1:0]  IP_LAST    = IP_W'(IQ_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Wrap an in-flight FIFO pointer modulo MAX_OUT.
  function automatic logic [OP_W-1:0] op_inc(input logic [OP_W-1:0] p);
    return (p == OP_LAST) ? '0 : p + 1'b1;
  endfunction

  // Wrap an instruction-queue pointer modulo IQ_DEPTH.
  function automatic logic [IP_W-1:0] ip_inc(input logic [IP_W-1:0] p);
    return (p == IP_LAST) ? '0 : p + 1'b1;
  endfunction

  // Fetch control state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             epoch_q,    epoch_d;
  logic             halted_q,   halted_d;
  logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;

  // In-flight FIFO: pointers are control, entries are data
  logic [OP_W-1:0]  of_wr_q, of_wr_d;
  logic [OP_W-1:0]  of_rd_q, of_rd_d;
  logic [31:0]      of_pc_mem [MAX_OUT];
  logic             of_ep_mem [MAX_OUT];

  // Instruction queue
  logic [IP_W-1:0]  iq_wr_q,  iq_wr_d;
  logic [IP_W-1:0]  iq_rd_q,  iq_rd_d;
  logic [CNT_W-1:0] iq_cnt_q, iq_cnt_d;
  logic [31:0]      iq_pc_mem   [IQ_DEPTH];
  logic [31:0]      iq_inst_mem [IQ_DEPTH];
  logic             iq_adef_mem [IQ_DEPTH];

  // Per-cycle decisions
  logic             redirect;
  logic [31:0]      redir_tgt;
  logic [31:0]      next_addr;
  logic             epoch_new;
  logic [CNT_W-1:0] iq_cnt_eff;
  logic             aligned;
  logic             req;
  logic             issue;
  logic             resp;
  logic             resp_keep;
  logic             adef_push;
  logic             iq_push;
  logic             iq_pop;
  logic [31:0]      iq_push_pc;
  logic [31:0]      iq_push_inst;
  logic             iq_push_adef;

  // Redirect source priority: exception over ertn over branch.
  always_comb begin
    redirect  = ex_valid | ertn_valid | br_taken;
    redir_tgt = br_target;
    if (ex_valid) begin
      redir_tgt = ex_entry;
    end else if (ertn_valid) begin
      redir_tgt = era_pc;
    end
  end

  assign next_addr  = redirect ? redir_tgt : fetch_pc_q;
  // A request issued in the redirect cycle already belongs to the new epoch.
  assign epoch_new  = epoch_q ^ redirect;
  // The queue is flushed on redirect, so its slots are free for new credits.
  assign iq_cnt_eff = redirect ? '0 : iq_cnt_q;
  assign aligned    = (next_addr[1:0] == 2'b00);

  // Credit rule: every outstanding request must have a guaranteed queue slot.
  assign req = ~reset & ~br_stall & ~halted_q & aligned
             & (out_cnt_q < MAX_OUT_C)
             & ((out_cnt_q + iq_cnt_eff) < IQ_DEPTH_C);
  assign issue = req & inst_sram_addr_ok;

  // A response with nothing outstanding is a protocol violation and ignored.
  assign resp      = inst_sram_data_ok & (out_cnt_q != '0);
  assign resp_keep = resp & ~redirect & (of_ep_mem[of_rd_q] == epoch_new);

  // Misaligned fetch: wait for older responses to drain, then queue one ADEF.
  assign adef_push = ~reset & ~redirect & ~halted_q & ~aligned
                   & (out_cnt_q == '0) & (iq_cnt_q < IQ_DEPTH_C);

  // resp_keep needs out_cnt != 0 and adef_push needs out_cnt == 0: never both.
  assign iq_push      = resp_keep | adef_push;
  assign iq_pop       = (iq_cnt_q != '0) & out_ready & ~redirect;
  assign iq_push_pc   = resp_keep ? of_pc_mem[of_rd_q] : next_addr;
  assign iq_push_inst = resp_keep ? inst_sram_rdata : 32'h0;
  assign iq_push_adef = ~resp_keep;

  // Next-state for fetch PC, epoch, halt flag and in-flight bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_new;
    halted_d   = halted_q;
    out_cnt_d  = out_cnt_q;
    of_wr_d    = of_wr_q;
    of_rd_d    = of_rd_q;

    if (issue) begin
      fetch_pc_d = next_addr + 32'd4;
    end else if (redirect) begin
      fetch_pc_d = redir_tgt;
    end

    if (redirect) begin
      halted_d = 1'b0;
    end else if (adef_push) begin
      halted_d = 1'b1;
    end

    if (issue) begin
      of_wr_d = op_inc(of_wr_q);
    end
    if (resp) begin
      of_rd_d = op_inc(of_rd_q);
    end

    case ({issue, resp})
      2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Next-state for the instruction queue; a redirect empties it outright.
  always_comb begin
    iq_wr_d  = iq_wr_q;
    iq_rd_d  = iq_rd_q;
    iq_cnt_d = iq_cnt_q;

    if (redirect) begin
      iq_wr_d  = '0;
      iq_rd_d  = '0;
      iq_cnt_d = '0;
    end else begin
      if (iq_push) begin
        iq_wr_d = ip_inc(iq_wr_q);
      end
      if (iq_pop) begin
        iq_rd_d = ip_inc(iq_rd_q);
      end
      case ({iq_push, iq_pop})
        2'b10:   iq_cnt_d = iq_cnt_q + CNT_ONE;
        2'b01:   iq_cnt_d = iq_cnt_q - CNT_ONE;
        default: iq_cnt_d = iq_cnt_q;
      endcase
    end
  end

  // Control registers; reset drops every outstanding request and queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
      halted_q   <= 1'b0;
      out_cnt_q  <= '0;
      of_wr_q    <= '0;
      of_rd_q    <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
      iq_cnt_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      halted_q   <= halted_d;
      out_cnt_q  <= out_cnt_d;
      of_wr_q    <= of_wr_d;
      of_rd_q    <= of_rd_d;
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
      iq_cnt_q   <= iq_cnt_d;
    end
  end

  // In-flight FIFO storage: address and epoch of each issued request.
  always_ff @(posedge clk) begin
    if (issue) begin
      of_pc_mem[of_wr_q] <= next_addr;
      of_ep_mem[of_wr_q] <= epoch_new;
    end
  end

  // Instruction queue storage: returned instructions and ADEF markers.
  always_ff @(posedge clk) begin
    if (iq_push & ~redirect) begin
      iq_pc_mem[iq_wr_q]   <= iq_push_pc;
      iq_inst_mem[iq_wr_q] <= iq_push_inst;
      iq_adef_mem[iq_wr_q] <= iq_push_adef;
    end
  end

  assign inst_sram_req   = req;
  assign inst_sram_addr  = next_addr;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign out_valid = ~reset & (iq_cnt_q != '0);
  assign out_pc    = iq_pc_mem[iq_rd_q];
  assign out_inst  = iq_inst_mem[iq_rd_q];
  assign out_adef  = out_valid & iq_adef_mem[iq_rd_q];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: an SRAM model answers issued fetches after a
// programmable latency, and a scoreboard of expected {pc, inst, adef} entries
// is compared against every accepted output of the queue.
module tb_if_fetch_queue;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ex_valid;
  logic [31:0] ex_entry;
  logic        ertn_valid;
  logic [31:0] era_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_stall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adef;

  if_fetch_queue dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .ex_valid          (ex_valid),
    .ex_entry          (ex_entry),
    .ertn_valid        (ertn_valid),
    .era_pc            (era_pc),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .br_stall          (br_stall),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_inst          (out_inst),
    .out_adef          (out_adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  mem_t mem_q [$];
  exp_t sb [$];

  int          total;
  int          passed;
  int          cyc;
  int          lat;
  int          n_issue;
  int          n_out;
  int          first_out_cyc;
  int          last_out_cyc;
  logic        chk_addr;
  logic [31:0] exp_addr;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mfun(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00ff_ff00;
  endfunction

  // One clock cycle: drive the SRAM response, observe issue and output
  // handshakes mid-cycle, then advance to the next falling edge.
  task automatic tick();
    logic resp;
    exp_t e;
    resp = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_q[0].data;
      resp              = 1'b1;
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'hdead_beef;
    end
    #1;
    if (inst_sram_req && inst_sram_addr_ok) begin
      mem_q.push_back('{due: cyc + lat, data: mfun(inst_sram_addr)});
      n_issue++;
      if (chk_addr) begin
        total++;
        if (inst_sram_addr !== exp_addr)
          $display("FAIL issue_addr: got %h expected %h (cycle %0d)", inst_sram_addr, exp_addr, cyc);
        else
          passed++;
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (out_valid && out_ready && !(ex_valid || ertn_valid || br_taken)) begin
      if (n_out == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      n_out++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_out: got pc %h inst %h adef %b, expected none", out_pc, out_inst, out_adef);
      end else begin
        e = sb.pop_front();
        if ({out_pc, out_inst, out_adef} !== {e.pc, e.inst, e.adef})
          $display("FAIL out_entry: got pc %h inst %h adef %b expected pc %h inst %h adef %b",
                   out_pc, out_inst, out_adef, e.pc, e.inst, e.adef);
        else
          passed++;
      end
    end
    if (resp) void'(mem_q.pop_front());
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_inputs();
    inst_sram_addr_ok = 1'b0;
    ex_valid   = 1'b0; ex_entry  = 32'h0;
    ertn_valid = 1'b0; era_pc    = 32'h0;
    br_taken   = 1'b0; br_target = 32'h0;
    br_stall   = 1'b0;
    out_ready  = 1'b0;
    chk_addr   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    mem_q.delete();
    sb.delete();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_issue = 0;
    n_out   = 0;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] pc;
      pc = base + 32'(4 * k);
      sb.push_back('{pc: pc, inst: mfun(pc), adef: 1'b0});
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (sb.size() == 0) break;
      tick();
    end
    total++;
    if (sb.size() != 0)
      $display("FAIL %s_timeout: got %0d entries outstanding, expected 0", name, sb.size());
    else
      passed++;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick();
    tick();
    #1;
    total++; if (inst_sram_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", inst_sram_req); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_adef !== 1'b0) $display("FAIL rst_out_adef: got %b expected 0", out_adef); else passed++;
    reset = 1'b0;
    #1;
    total++; if (inst_sram_req !== 1'b1) $display("FAIL post_rst_req: got %b expected 1", inst_sram_req); else passed++;
    total++; if (inst_sram_addr !== RPC) $display("FAIL post_rst_addr: got %h expected %h", inst_sram_addr, RPC); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (inst_sram_wr !== 1'b0) $display("FAIL const_wr: got %b expected 0", inst_sram_wr); else passed++;
    total++; if (inst_sram_size !== 2'b10) $display("FAIL const_size: got %b expected 10", inst_sram_size); else passed++;
    total++; if (inst_sram_wstrb !== 4'h0) $display("FAIL const_wstrb: got %h expected 0", inst_sram_wstrb); else passed++;
    total++; if (inst_sram_wdata !== 32'h0) $display("FAIL const_wdata: got %h expected 0", inst_sram_wdata); else passed++;
    inst_sram_addr_ok = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    push_seq(RPC, 16);
    lat = 1;
    chk_addr = 1'b1; exp_addr = RPC;
    inst_sram_addr_ok = 1'b1;
    out_ready = 1'b1;
    drain("basic", 60);
    total++;
    if (last_out_cyc - first_out_cyc !== 15)
      $display("FAIL basic_throughput: got span %0d cycles expected 15", last_out_cyc - first_out_cyc);
    else
      passed++;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1;
    inst_sram_addr_ok = 1'b1;
    out_ready = 1'b0;
    repeat (12) tick();
    #1;
    total++; if (n_issue !== 4) $display("FAIL bp_issue_count: got %0d expected 4", n_issue); else passed++;
    total++; if (inst_sram_req !== 1'b0) $display("FAIL bp_req_drop: got %b expected 0", inst_sram_req); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", out_valid); else passed++;
    push_seq(RPC, 10);
    chk_addr = 1'b1; exp_addr = RPC + 32'd16;
    out_ready = 1'b1;
    drain("backpressure", 60);
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    lat = 3;
    inst_sram_addr_ok = 1'b1;
    out_ready = 1'b0;
    repeat (6) tick();
    #1;
    total++; if (n_issue !== 4) $display("FAIL br_pre_issue: got %0d expected 4", n_issue); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL br_pre_valid: got %b expected 1", out_valid); else passed++;
    br_taken  = 1'b1;
    br_target = 32'h1c000100;
    tick();
    br_taken = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL br_flush: got out_valid %b expected 0", out_valid); else passed++;
    push_seq(32'h1c000100, 5);
    chk_addr = 1'b1; exp_addr = 32'h1c000100;
    out_ready = 1'b1;
    drain("branch", 60);
    clear_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    ex_valid = 1'b1;   ex_entry  = 32'h1c008000;
    ertn_valid = 1'b1; era_pc    = 32'h1c00a000;
    br_taken = 1'b1;   br_target = 32'h1c000200;
    #1;
    total++; if (inst_sram_addr !== 32'h1c008000) $display("FAIL prio_ex: got %h expected 1c008000", inst_sram_addr); else passed++;
    ex_valid = 1'b0;
    #1;
    total++; if (inst_sram_addr !== 32'h1c00a000) $display("FAIL prio_ertn: got %h expected 1c00a000", inst_sram_addr); else passed++;
    ertn_valid = 1'b0;
    #1;
    total++; if (inst_sram_addr !== 32'h1c000200) $display("FAIL prio_br: got %h expected 1c000200", inst_sram_addr); else passed++;
    br_taken = 1'b0;
    br_stall = 1'b1;
    #1;
    total++; if (inst_sram_req !== 1'b0) $display("FAIL stall_req: got %b expected 0", inst_sram_req); else passed++;
    clear_inputs();
  endtask

  task automatic test_adef();
    do_reset();
    lat = 1;
    inst_sram_addr_ok = 1'b1;
    out_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h1c000102;
    #1;
    total++; if (inst_sram_req !== 1'b0) $display("FAIL adef_req_redirect: got %b expected 0", inst_sram_req); else passed++;
    tick();
    br_taken = 1'b0;
    sb.push_back('{pc: 32'h1c000102, inst: 32'h0, adef: 1'b1});
    repeat (8) tick();
    #1;
    total++; if (n_issue !== 0) $display("FAIL adef_no_issue: got %0d issues expected 0", n_issue); else passed++;
    total++; if (n_out !== 1) $display("FAIL adef_single: got %0d outputs expected 1", n_out); else passed++;
    total++; if (inst_sram_req !== 1'b0) $display("FAIL adef_halted: got req %b expected 0", inst_sram_req); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL adef_after_pop: got out_valid %b expected 0", out_valid); else passed++;
    ex_valid = 1'b1;
    ex_entry = 32'h1c000300;
    push_seq(32'h1c000300, 3);
    chk_addr = 1'b1; exp_addr = 32'h1c000300;
    tick();
    ex_valid = 1'b0;
    drain("adef_resume", 40);
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lat = 3;
    inst_sram_addr_ok = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    total++; if (n_issue !== 2) $display("FAIL mid_pre_issue: got %0d expected 2", n_issue); else passed++;
    reset = 1'b1;
    inst_sram_addr_ok = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (out_valid !== 1'b0)
        $display("FAIL mid_stale_valid: got %b expected 0 (step %0d)", out_valid, k);
      else
        passed++;
      tick();
    end
    #1;
    total++; if (inst_sram_req !== 1'b1) $display("FAIL mid_req: got %b expected 1", inst_sram_req); else passed++;
    total++; if (inst_sram_addr !== RPC) $display("FAIL mid_addr: got %h expected %h", inst_sram_addr, RPC); else passed++;
    push_seq(RPC, 3);
    lat = 1;
    chk_addr = 1'b1; exp_addr = RPC;
    inst_sram_addr_ok = 1'b1;
    drain("midflight", 40);
    clear_inputs();
  endtask

  initial begin
    total = 0; passed = 0; cyc = 0; lat = 1;
    n_issue = 0; n_out = 0; first_out_cyc = 0; last_out_cyc = 0;
    exp_addr = RPC;
    reset = 1'b1;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_priority();
    test_adef();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUT, default 2, max in-flight inst requests (power of 2, 1..8).
REQ-003 SHALL have parameter IQ_DEPTH, default 4, instruction queue entries (power of 2, >= MAX_OUT).
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 (reset reset, synchronous, active-high; clock clk).
REQ-005 SHALL have ports: inst_sram_req out 1; inst_sram_wr out 1; inst_sram_size out 2; inst_sram_addr out 32; inst_sram_wstrb out 4; inst_sram_wdata out 32.
REQ-006 SHALL have ports: inst_sram_addr_ok in 1; inst_sram_data_ok in 1; inst_sram_rdata in 32.
REQ-007 SHALL have ports: ex_valid in 1, ex_entry in 32; ertn_valid in 1, era_pc in 32; br_taken in 1, br_target in 32; br_stall in 1.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1 (ID allow-in); out_pc out 32; out_inst out 32; out_adef out 1.

Function
REQ-009 SHALL drive inst_sram_wr=0, wstrb=0, wdata=0, size=2'b10 constantly.
REQ-010 SHALL select redirect: ex_valid -> ex_entry, else ertn_valid -> era_pc, else br_taken -> br_target; redirect = any of the three.
REQ-011 SHALL form next address = redirect target when redirect, else fetch_pc; inst_sram_addr = next address.
REQ-012 SHALL assert inst_sram_req iff ~reset, ~br_stall, ~halted, next address[1:0]==0, out_cnt<MAX_OUT, out_cnt+iq_cnt_eff<IQ_DEPTH, where iq_cnt_eff = 0 on redirect else current iq count.
REQ-013 SHALL treat req&addr_ok as issue: push {address, current-or-new epoch} into in-flight FIFO, out_cnt+1, fetch_pc <= address+4.
REQ-014 SHALL on redirect without issue set fetch_pc <= redirect target.
REQ-015 SHALL keep a 1-bit epoch; redirect toggles it; a request issued in the redirect cycle carries the new epoch.
REQ-016 SHALL on data_ok pop in-flight FIFO head, out_cnt-1; if head epoch == current epoch (after this cycle's toggle) and no redirect this cycle, push {head pc, rdata, adef=0} into IQ; else discard.
REQ-017 SHALL handle simultaneous issue and data_ok: out_cnt unchanged, both FIFO ops performed.
REQ-018 SHALL on redirect flush IQ (count 0) in that cycle; any same-cycle output handshake is void.
REQ-019 SHALL on misaligned next address (no redirect pending block) when out_cnt==0 and IQ not full push {address, inst 0, adef=1} into IQ and set halted; no SRAM request for it.
REQ-020 SHALL clear halted only on redirect.
REQ-021 SHALL present IQ head: out_valid = IQ non-empty; pop on out_valid&out_ready; push and pop same cycle allowed when not empty.
REQ-022 SHALL have latency: data_ok in cycle N -> out_valid earliest N+1 (no bypass).
REQ-023 SHALL never overflow IQ: credit rule of REQ-012 guarantees a slot for every in-flight response.
REQ-024 SHALL ignore data_ok when out_cnt==0 (protocol violation, no state change).
REQ-025 SHALL wrap FIFO pointers modulo depth; full/empty from counts.

Reset
REQ-026 SHALL on reset: fetch_pc=RESET_PC, epoch=0, halted=0, out_cnt=0, IQ empty, in-flight FIFO empty.
REQ-027 SHALL during reset hold inst_sram_req=0, out_valid=0, out_adef=0; out_pc/out_inst don't-care while out_valid=0.
REQ-028 SHALL on reset mid-operation drop all in-flight state; late data_ok after reset is ignored per REQ-024.

Verification
REQ-029 Basic: addr_ok=1, data_ok 1 cycle after issue, out_ready=1 -> addresses 1c000000,1c000004,... in order, out_pc matches, one inst/cycle sustained.
REQ-030 Backpressure: out_ready=0 -> at most IQ_DEPTH requests accepted in total (4 default), req drops, no inst lost after out_ready=1.
REQ-031 Branch with 2 in flight: br_taken, br_target=1c000100 -> both stale responses discarded, next out_pc=1c000100, IQ flushed same cycle.
REQ-032 Priority: ex_valid+ertn_valid+br_taken same cycle, ex_entry=1c008000 -> inst_sram_addr=1c008000 that cycle.
REQ-033 ADEF: br_target=1c000102 -> no SRAM req, single out entry out_pc=1c000102 out_adef=1, fetch halted until ex_valid redirect.
REQ-034 Reset mid-flight: reset with out_cnt=2, then data_ok pulses -> no out_valid, first request after reset at RESET_PC.
